// File: rtl/beacon_pkg.sv
// Shared types and width helpers for the multi-lag beacon correlator.
package beacon_pkg;

  typedef enum logic {IDLE, SCAN} scan_state_e;

  // Smallest r with 2**r >= v; 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned b = 0; b < 32; b++) begin
      if ((64'd1 << b) < 64'(v)) r = b + 1;
    end
    return r;
  endfunction

  function automatic int unsigned acc_w(input int unsigned code_len);
    return clog2(code_len + 1);
  endfunction

  function automatic int unsigned lag_w(input int unsigned lags);
    return (clog2(lags) < 1) ? 1 : clog2(lags);
  endfunction

endpackage

// File: rtl/lag_peak_scan.sv
// Serial peak search over the per-lag window counts, plus the lock counter.
module lag_peak_scan
  import beacon_pkg::*;
#(
  parameter int unsigned LAGS     = 4,
  parameter int unsigned ACC_W    = 9,
  parameter int unsigned LAG_W    = 2,
  parameter int unsigned LOCK_CNT = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [LAGS*ACC_W-1:0] i_value,
  input  logic [ACC_W-1:0]      i_threshold,
  output logic [LAG_W-1:0]      o_peak_lag,
  output logic [ACC_W-1:0]      o_peak_value,
  output logic                  o_peak_valid,
  output logic                  o_locked
);
  localparam int unsigned CNT_W = clog2(LOCK_CNT + 1);

  scan_state_e      r_state, w_state_nxt;
  logic [LAG_W-1:0] r_idx, r_best_idx, r_peak_lag, w_best_idx_nxt;
  logic [ACC_W-1:0] r_best, r_peak_value, w_cur, w_best_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_peak_valid, w_last, w_finish, w_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_cur = '0;
    for (int unsigned k = 0; k < LAGS; k++) begin
      if (r_idx == LAG_W'(k)) w_cur = i_value[k*ACC_W +: ACC_W];
    end
    // Strict compare keeps the lowest index on ties.
    w_best_nxt     = (w_cur > r_best) ? w_cur : r_best;
    w_best_idx_nxt = (w_cur > r_best) ? r_idx : r_best_idx;
    w_last         = (r_idx == LAG_W'(LAGS - 1));

    w_state_nxt = r_state;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: if (i_start) w_state_nxt = SCAN;
      SCAN: if (w_last) begin
        w_state_nxt = IDLE;
        w_finish    = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (i_abort) begin
      w_state_nxt = IDLE;
      w_finish    = 1'b0;
    end

    w_hit = (w_best_nxt >= i_threshold);
    if (!w_hit)                             w_cnt_nxt = '0;
    else if (w_best_idx_nxt != r_peak_lag)  w_cnt_nxt = CNT_W'(1);
    else if (r_cnt == CNT_W'(LOCK_CNT))     w_cnt_nxt = r_cnt;
    else                                    w_cnt_nxt = r_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx        <= '0;
      r_best       <= '0;
      r_best_idx   <= '0;
      r_peak_lag   <= '0;
      r_peak_value <= '0;
      r_peak_valid <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_peak_valid <= w_finish;
      if (r_state == IDLE) begin
        r_idx      <= '0;
        r_best     <= '0;
        r_best_idx <= '0;
      end else begin
        r_idx      <= r_idx + LAG_W'(1);
        r_best     <= w_best_nxt;
        r_best_idx <= w_best_idx_nxt;
      end
      if (w_finish) begin
        r_peak_lag   <= w_best_idx_nxt;
        r_peak_value <= w_best_nxt;
        r_cnt        <= w_cnt_nxt;
      end
    end
  end

  assign o_peak_lag   = r_peak_lag;
  assign o_peak_value = r_peak_value;
  assign o_peak_valid = r_peak_valid;
  assign o_locked     = (r_cnt == CNT_W'(LOCK_CNT));

endmodule

// File: rtl/beacon_lag_correlator.sv
// Multi-lag 1-bit correlator: per-lag agreement counts over one code period,
// followed by a peak scan and lock detection.
module beacon_lag_correlator
  import beacon_pkg::*;
#(
  parameter int unsigned LAGS     = 4,
  parameter int unsigned CODE_LEN = 256,
  parameter int unsigned LOCK_CNT = 3,
  localparam int unsigned PH_W  = clog2(CODE_LEN),
  localparam int unsigned ACC_W = acc_w(CODE_LEN),
  localparam int unsigned LAG_W = lag_w(LAGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sig,
  input  logic                  code,
  input  logic [PH_W-1:0]       shift,
  input  logic                  shift_load,
  input  logic [ACC_W-1:0]      threshold,
  output logic [LAGS*ACC_W-1:0] value,
  output logic                  value_valid,
  output logic [LAG_W-1:0]      peak_lag,
  output logic [ACC_W-1:0]      peak_value,
  output logic                  peak_valid,
  output logic                  locked
);
  logic                  r_sig_q;
  logic [LAGS-1:0]       r_cd;
  logic [PH_W-1:0]       r_ph;
  logic [ACC_W-1:0]      r_acc [LAGS];
  logic [LAGS*ACC_W-1:0] r_value;
  logic                  r_value_valid;
  logic [LAGS-1:0]       w_agree;
  logic                  w_dump;
  logic                  w_start;

  // r_cd[0] doubles as the registered code bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig_q <= 1'b0;
      r_cd    <= '0;
    end else begin
      r_sig_q <= sig;
      r_cd    <= {r_cd[LAGS-2:0], code};
    end
  end

  assign w_agree = {LAGS{r_sig_q}} ~^ r_cd;
  assign w_dump  = (r_ph == PH_W'(CODE_LEN - 1));
  assign w_start = w_dump && !shift_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ph          <= '0;
      r_value       <= '0;
      r_value_valid <= 1'b0;
      for (int unsigned k = 0; k < LAGS; k++) r_acc[k] <= '0;
    end else begin
      r_value_valid <= 1'b0;
      if (shift_load) begin
        r_ph <= shift;
        for (int unsigned k = 0; k < LAGS; k++) r_acc[k] <= '0;
      end else if (w_dump) begin
        r_ph          <= '0;
        r_value_valid <= 1'b1;
        for (int unsigned k = 0; k < LAGS; k++) begin
          r_value[k*ACC_W +: ACC_W] <= r_acc[k] + ACC_W'(w_agree[k]);
          r_acc[k]                  <= '0;
        end
      end else begin
        r_ph <= r_ph + PH_W'(1);
        for (int unsigned k = 0; k < LAGS; k++) r_acc[k] <= r_acc[k] + ACC_W'(w_agree[k]);
      end
    end
  end

  lag_peak_scan #(
    .LAGS     (LAGS),
    .ACC_W    (ACC_W),
    .LAG_W    (LAG_W),
    .LOCK_CNT (LOCK_CNT)
  ) u_scan (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_start      (w_start),
    .i_abort      (shift_load),
    .i_value      (r_value),
    .i_threshold  (threshold),
    .o_peak_lag   (peak_lag),
    .o_peak_value (peak_value),
    .o_peak_valid (peak_valid),
    .o_locked     (locked)
  );

  assign value       = r_value;
  assign value_valid = r_value_valid;

endmodule
